// File: rtl/nib_core_arb.sv
// Two-master arbiter placing core0/core1 execute-stage data ports onto the single NIB data master.
// Round-robin with bounded bursts, read-data steering by tag pipeline, and activation-register intercept.
module nib_core_arb #(
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [31:0] ACT_ADDR   = 32'h0000_3FF0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_wdata_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_hold_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_wdata_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_hold_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  output logic [1:0]  core_activate_o,
  output logic [1:0]  core_bus_spare_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  last_owner_q, last_owner_d;
  logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0] tag_id_q, tag_id_d;
  logic [1:0]            act_q, act_d;

  logic        eo_vld;
  logic        eo_id;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        intercept;
  logic        same_owner;

  // Effective owner for this cycle from state, burst count and both requests.
  always_comb begin
    eo_vld = 1'b0;
    eo_id  = 1'b0;
    case (state_q)
      OWN0: begin
        if (m0_req_i && ((cnt_q < MAX_BURST_C) || !m1_req_i)) begin
          eo_vld = 1'b1;
          eo_id  = 1'b0;
        end else if (m1_req_i) begin
          eo_vld = 1'b1;
          eo_id  = 1'b1;
        end else begin
          eo_vld = 1'b0;
          eo_id  = 1'b0;
        end
      end
      OWN1: begin
        if (m1_req_i && ((cnt_q < MAX_BURST_C) || !m0_req_i)) begin
          eo_vld = 1'b1;
          eo_id  = 1'b1;
        end else if (m0_req_i) begin
          eo_vld = 1'b1;
          eo_id  = 1'b0;
        end else begin
          eo_vld = 1'b0;
          eo_id  = 1'b0;
        end
      end
      default: begin
        // IDLE (and the unused encoding): ties go to the master that did not issue last
        if (m0_req_i && m1_req_i) begin
          eo_vld = 1'b1;
          eo_id  = ~last_owner_q;
        end else if (m0_req_i) begin
          eo_vld = 1'b1;
          eo_id  = 1'b0;
        end else if (m1_req_i) begin
          eo_vld = 1'b1;
          eo_id  = 1'b1;
        end else begin
          eo_vld = 1'b0;
          eo_id  = 1'b0;
        end
      end
    endcase
  end

  // Bus mux, activation intercept, holds and bus-spare flags.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = 32'h0;
    sel_wdata = 32'h0;
    if (eo_vld && eo_id) begin
      sel_we    = m1_we_i;
      sel_addr  = m1_addr_i;
      sel_wdata = m1_wdata_i;
    end else if (eo_vld) begin
      sel_we    = m0_we_i;
      sel_addr  = m0_addr_i;
      sel_wdata = m0_wdata_i;
    end else begin
      sel_we    = 1'b0;
      sel_addr  = 32'h0;
      sel_wdata = 32'h0;
    end
    intercept           = eo_vld & sel_we & (sel_addr == ACT_ADDR);
    bus_req_o           = eo_vld & ~intercept;
    bus_we_o            = sel_we;
    bus_addr_o          = sel_addr;
    bus_wdata_o         = sel_wdata;
    m0_hold_o           = m0_req_i & ~(eo_vld & ~eo_id);
    m1_hold_o           = m1_req_i & ~(eo_vld & eo_id);
    core_bus_spare_o[0] = ~(eo_vld & eo_id);
    core_bus_spare_o[1] = ~(eo_vld & ~eo_id);
  end

  // Next state: ownership, saturating burst count, activation bits and read-tag shift.
  always_comb begin
    state_d      = IDLE;
    cnt_d        = 4'd0;
    last_owner_d = last_owner_q;
    act_d        = act_q;
    tag_vld_d    = '0;
    tag_id_d     = '0;
    same_owner   = ((state_q == OWN0) && !eo_id) || ((state_q == OWN1) && eo_id);
    if (eo_vld) begin
      state_d      = eo_id ? OWN1 : OWN0;
      last_owner_d = eo_id;
      if (same_owner) begin
        cnt_d = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd1;
      end
    end else begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end
    if (intercept) begin
      act_d = sel_wdata[1:0];
    end else begin
      act_d = act_q;
    end
    // Intercepted beats are always writes, so a read beat always reaches the NIB
    tag_vld_d[0] = eo_vld & ~sel_we;
    tag_id_d[0]  = eo_id;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  // Read-data steering from the tail of the tag pipeline.
  always_comb begin
    m0_rdata_o = 32'h0;
    m1_rdata_o = 32'h0;
    if (tag_vld_q[RD_LATENCY-1] && tag_id_q[RD_LATENCY-1]) begin
      m1_rdata_o = bus_rdata_i;
    end else if (tag_vld_q[RD_LATENCY-1]) begin
      m0_rdata_o = bus_rdata_i;
    end else begin
      m0_rdata_o = 32'h0;
      m1_rdata_o = 32'h0;
    end
  end

  assign core_activate_o = act_q;

  // State registers; reset discards any in-flight read tags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_owner_q <= 1'b1;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      act_q        <= 2'b01;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      act_q        <= act_d;
    end
  end

endmodule

// File: tb/tb_nib_core_arb.sv
// Bench for nib_core_arb: two instances (RD_LATENCY 1 and 2) share stimulus; a small NIB model
// answers reads and a per-instance queue scores returned read data.
module tb_nib_core_arb;

  localparam int          LAT_A = 1;
  localparam int          LAT_B = 2;
  localparam logic [31:0] KEY   = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;

  logic [31:0] a_m0_rdata, a_m1_rdata, a_bus_addr, a_bus_wdata, a_bus_rdata;
  logic        a_m0_hold, a_m1_hold, a_bus_req, a_bus_we;
  logic [1:0]  a_act, a_spare;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_bus_addr, b_bus_wdata, b_bus_rdata;
  logic        b_m0_hold, b_m1_hold, b_bus_req, b_bus_we;
  logic [1:0]  b_act, b_spare;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t        mon_e;
  logic [31:0] mon_x0, mon_x1;
  logic [31:0] nib_a, nib_b0, nib_b1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  nib_core_arb #(.MAX_BURST(4), .RD_LATENCY(LAT_A), .ACT_ADDR(32'h0000_3FF0)) u_dut_a (
    .clk(clk), .rstn(rstn),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_wdata_i(m0_wdata),
    .m0_rdata_o(a_m0_rdata), .m0_hold_o(a_m0_hold),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_wdata_i(m1_wdata),
    .m1_rdata_o(a_m1_rdata), .m1_hold_o(a_m1_hold),
    .bus_req_o(a_bus_req), .bus_addr_o(a_bus_addr), .bus_we_o(a_bus_we),
    .bus_wdata_o(a_bus_wdata), .bus_rdata_i(a_bus_rdata),
    .core_activate_o(a_act), .core_bus_spare_o(a_spare)
  );

  nib_core_arb #(.MAX_BURST(4), .RD_LATENCY(LAT_B), .ACT_ADDR(32'h0000_3FF0)) u_dut_b (
    .clk(clk), .rstn(rstn),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_wdata_i(m0_wdata),
    .m0_rdata_o(b_m0_rdata), .m0_hold_o(b_m0_hold),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_wdata_i(m1_wdata),
    .m1_rdata_o(b_m1_rdata), .m1_hold_o(b_m1_hold),
    .bus_req_o(b_bus_req), .bus_addr_o(b_bus_addr), .bus_we_o(b_bus_we),
    .bus_wdata_o(b_bus_wdata), .bus_rdata_i(b_bus_rdata),
    .core_activate_o(b_act), .core_bus_spare_o(b_spare)
  );

  // NIB model: read data = addr ^ KEY after the latency, junk otherwise; never reset.
  always @(posedge clk) begin
    nib_a  <= (a_bus_req && !a_bus_we) ? (a_bus_addr ^ KEY) : 32'hDEAD_BEEF;
    nib_b0 <= (b_bus_req && !b_bus_we) ? (b_bus_addr ^ KEY) : 32'hDEAD_BEEF;
    nib_b1 <= nib_b0;
  end
  assign a_bus_rdata = nib_a;
  assign b_bus_rdata = nib_b1;

  // Scoreboard: pop the expected read return when due, otherwise rdata must stay zero.
  always @(negedge clk) begin
    if (qa.size() > 0 && qa[0].due == cyc) begin
      mon_e  = qa.pop_front();
      mon_x0 = mon_e.id ? 32'h0 : mon_e.data;
      mon_x1 = mon_e.id ? mon_e.data : 32'h0;
      total++;
      if ({a_m0_rdata, a_m1_rdata} !== {mon_x0, mon_x1}) begin
        bad++;
        $display("FAIL rdata_lat1 cyc=%0d got m0=%h m1=%h want m0=%h m1=%h",
                 cyc, a_m0_rdata, a_m1_rdata, mon_x0, mon_x1);
      end
    end else if (a_m0_rdata !== 32'h0 || a_m1_rdata !== 32'h0) begin
      total++;
      bad++;
      $display("FAIL rdata_lat1_spurious cyc=%0d got m0=%h m1=%h want 0", cyc, a_m0_rdata, a_m1_rdata);
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      mon_e  = qb.pop_front();
      mon_x0 = mon_e.id ? 32'h0 : mon_e.data;
      mon_x1 = mon_e.id ? mon_e.data : 32'h0;
      total++;
      if ({b_m0_rdata, b_m1_rdata} !== {mon_x0, mon_x1}) begin
        bad++;
        $display("FAIL rdata_lat2 cyc=%0d got m0=%h m1=%h want m0=%h m1=%h",
                 cyc, b_m0_rdata, b_m1_rdata, mon_x0, mon_x1);
      end
    end else if (b_m0_rdata !== 32'h0 || b_m1_rdata !== 32'h0) begin
      total++;
      bad++;
      $display("FAIL rdata_lat2_spurious cyc=%0d got m0=%h m1=%h want 0", cyc, b_m0_rdata, b_m1_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
  endtask

  task automatic push_read(input logic id, input logic [31:0] addr);
    exp_t e;
    e.id   = id;
    e.data = addr ^ KEY;
    e.due  = cyc + LAT_A;
    qa.push_back(e);
    e.due  = cyc + LAT_B;
    qb.push_back(e);
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b1;
    #2;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if ({a_bus_req, a_m0_hold, a_m1_hold, a_spare, a_act} !== {1'b0, 1'b0, 1'b0, 2'b11, 2'b01}) begin
      bad++;
      $display("FAIL reset_state got req/h0/h1/spare/act=%b want 0_0_0_11_01",
               {a_bus_req, a_m0_hold, a_m1_hold, a_spare, a_act});
    end
    tick();
  endtask

  task automatic test_tie_reads();
    int n0 = 0;
    int n1 = 0;
    logic gnt;
    logic [31:0] ea;
    for (int c = 0; c < 10; c++) begin
      m0_req = (n0 < 6); m0_we = 1'b0; m0_addr = 32'h0000_1000 + 32'(n0 * 4);
      m1_req = (n1 < 4); m1_we = 1'b0; m1_addr = 32'h0000_2000 + 32'(n1 * 4);
      gnt = (c >= 4 && c < 8);
      ea  = gnt ? m1_addr : m0_addr;
      @(negedge clk);
      total++;
      if ({a_bus_req, a_bus_we, a_bus_addr, a_m0_hold, a_m1_hold} !==
          {1'b1, 1'b0, ea, m0_req & gnt, m1_req & ~gnt}) begin
        bad++;
        $display("FAIL tie_beat c=%0d got req=%b we=%b addr=%h h0=%b h1=%b want addr=%h owner=%0d",
                 c, a_bus_req, a_bus_we, a_bus_addr, a_m0_hold, a_m1_hold, ea, gnt);
      end
      push_read(gnt, ea);
      if (gnt) n1++; else n0++;
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL tie_drain got pending=%0d/%0d want 0/0", qa.size(), qb.size());
    end
  endtask

  task automatic test_write_stream();
    for (int c = 0; c < 10; c++) begin
      m0_req = 1'b1; m0_we = 1'b1;
      m0_addr = 32'h0000_4000 + 32'(c * 4); m0_wdata = 32'hC0DE_0000 + 32'(c);
      @(negedge clk);
      total++;
      if ({a_bus_req, a_bus_we, a_bus_addr, a_bus_wdata, a_m0_hold, a_spare} !==
          {1'b1, 1'b1, m0_addr, m0_wdata, 1'b0, 2'b01}) begin
        bad++;
        $display("FAIL write_stream c=%0d got req=%b we=%b addr=%h wdata=%h hold=%b spare=%b want addr=%h wdata=%h",
                 c, a_bus_req, a_bus_we, a_bus_addr, a_bus_wdata, a_m0_hold, a_spare, m0_addr, m0_wdata);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_intercept();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_3FF0; m0_wdata = 32'h0000_0003;
    @(negedge clk);
    total++;
    if ({a_bus_req, a_m0_hold, a_act, a_spare} !== {1'b0, 1'b0, 2'b01, 2'b01}) begin
      bad++;
      $display("FAIL intercept_beat got req/hold/act/spare=%b want 0_0_01_01",
               {a_bus_req, a_m0_hold, a_act, a_spare});
    end
    tick();
    idle_inputs();
    @(negedge clk);
    total++;
    if ({a_act, b_act, a_bus_req} !== {2'b11, 2'b11, 1'b0}) begin
      bad++;
      $display("FAIL intercept_act got act_a=%b act_b=%b req=%b want 11 11 0", a_act, b_act, a_bus_req);
    end
    tick();
  endtask

  task automatic test_alt_reads();
    logic [31:0] addrs [3];
    logic        ids   [3];
    addrs[0] = 32'h0000_5000; ids[0] = 1'b0;
    addrs[1] = 32'h0000_6004; ids[1] = 1'b1;
    addrs[2] = 32'h0000_5008; ids[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      if (ids[c]) begin m1_req = 1'b1; m1_addr = addrs[c]; end
      else begin m0_req = 1'b1; m0_addr = addrs[c]; end
      @(negedge clk);
      total++;
      if ({a_bus_req, b_bus_req, a_bus_addr, b_bus_addr, a_m0_hold, a_m1_hold} !==
          {1'b1, 1'b1, addrs[c], addrs[c], 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL alt_beat c=%0d got addr_a=%h addr_b=%h h0=%b h1=%b want addr=%h",
                 c, a_bus_addr, b_bus_addr, a_m0_hold, a_m1_hold, addrs[c]);
      end
      push_read(ids[c], addrs[c]);
      tick();
    end
    idle_inputs();
    repeat (4) tick();
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL alt_drain got pending=%0d/%0d want 0/0", qa.size(), qb.size());
    end
  endtask

  task automatic test_reset_inflight();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_7000;
    @(negedge clk);
    push_read(1'b0, m0_addr);
    tick();
    idle_inputs();
    m1_req = 1'b1; m1_addr = 32'h0000_7104;
    @(negedge clk);
    total++;
    if ({a_bus_req, b_bus_req, a_bus_addr} !== {1'b1, 1'b1, 32'h0000_7104}) begin
      bad++;
      $display("FAIL inflight_beat got req=%b%b addr=%h want 11 00007104", a_bus_req, b_bus_req, a_bus_addr);
    end
    push_read(1'b1, m1_addr);
    tick();
    // Reset discards every read not yet delivered
    idle_inputs();
    rstn = 1'b0;
    qa.delete();
    qb.delete();
    @(negedge clk);
    total++;
    if ({a_m0_rdata, a_m1_rdata, b_m0_rdata, b_m1_rdata, a_act, b_act} !== {128'h0, 2'b01, 2'b01}) begin
      bad++;
      $display("FAIL inflight_reset got rdata_a=%h/%h rdata_b=%h/%h act=%b/%b want 0 and 01",
               a_m0_rdata, a_m1_rdata, b_m0_rdata, b_m1_rdata, a_act, b_act);
    end
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_8000; m0_wdata = 32'h0000_0011;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_9000; m1_wdata = 32'h0000_0022;
    @(negedge clk);
    total++;
    if ({a_bus_addr, b_bus_addr, a_m0_hold, a_m1_hold, b_m0_hold, b_m1_hold} !==
        {32'h0000_8000, 32'h0000_8000, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL post_reset_tie got addr=%h/%h holds=%b%b%b%b want 00008000 0101",
               a_bus_addr, b_bus_addr, a_m0_hold, a_m1_hold, b_m0_hold, b_m1_hold);
    end
    tick();
    idle_inputs();
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_tie_reads();
    test_write_stream();
    test_intercept();
    test_alt_reads();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
